serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, borrow-ripple subtractor computing `diff = a - b - bin` over `WIDTH` bits, one bit per clock, LSB first. It is the subtract-side counterpart of the arithmetic datapath's ripple adders. It trades the combinational borrow chain for a single full-subtractor cell plus shift registers, and uses a start/done/ack handshake. It sits beside the adder chain in the arithmetic datapath and serves callers that can tolerate `WIDTH`-cycle latency.

## Interface
Parameters:
- `WIDTH`, default 5: operand and result width; legal range 2..32.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `bin`  in  1  borrow-in; sampled on the accepting edge only.
- `ack`  in  1  consumer has taken the result; sampled only in DONE.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  high in DONE; result outputs valid.
- `diff`  out  WIDTH  difference, unsigned modulo 2^WIDTH.
- `bout`  out  1  borrow-out; 1 when `a < b + bin` unsigned.
- `ovf`  out  1  signed overflow, equal to borrow into MSB XOR `bout`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, `start`=1: latch `a`, `b` into shift registers and `bin` into the borrow flop. Clear the bit counter to 0 and go to RUN.
- RUN, each cycle, using bit0 of each shift register and borrow `br`:
  - `d = a0 ^ b0 ^ br`
  - `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - Shift `d` into the MSB of the diff register, which shifts right.
  - Shift both operand registers right and increment the counter.
- On the cycle the counter reaches `WIDTH-1`:
  - `bout` takes the final `br'`.
  - `ovf` takes the borrow going into the MSB XOR the final `br'`.
  - Next state is DONE.
- DONE: hold `diff`, `bout` and `ovf` stable. When `ack`=1, go to IDLE.
- `start` outside IDLE is ignored and the operation is not queued. This includes `start` and `ack` together in DONE: the block returns to IDLE and `start` must be reasserted.
- `ack` outside DONE is ignored.
- `diff`, `bout` and `ovf` retain their last values in IDLE. They change only during RUN.
- Arithmetic is unsigned modulo 2^WIDTH. Signed callers read `ovf`.
- Reset asserted at any time, including mid-RUN: all state is cleared immediately and the partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, state IDLE, counter 0.
- Accepting edge E: `busy`=1 from E.
- `done` rises after edge E+WIDTH, so latency is WIDTH cycles from acceptance to `done`.
- `ack` sampled high at edge F in DONE: `done` and `busy` are 0 after F.
- Earliest next acceptance is edge F+1.
- Throughput: at best one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then `a`=13, `b`=6, `bin`=0, `start` for 1 cycle -> `done` after exactly 5 edges, with `diff`=5'b00111, `bout`=0, `ovf`=0.
- `a`=6, `b`=13, `bin`=0 -> `diff`=5'b11001 (25), `bout`=1, `ovf`=0.
- `a`=0, `b`=0, `bin`=1 -> `diff`=5'b11111, `bout`=1. Then `a`=31, `b`=31, `bin`=0 -> `diff`=0, `bout`=0.
- Signed overflow: `a`=5'b01111 (+15), `b`=5'b10000 (-16) -> `diff`=5'b11111, `ovf`=1, `bout`=1.
- Handshake:
  - Hold `ack`=0 for 10 cycles in DONE -> `diff` is stable and `done` stays 1.
  - Pulse `start` with new operands during RUN and again in DONE -> ignored; result unchanged.
  - `ack` -> `done`=0 on the next edge.
- Assert `rst_n`=0 two cycles into RUN -> all outputs 0 immediately, without waiting for a clock edge.
  - After release, a fresh 13-6 operation returns 7 in 5 cycles.
- Exhaustive pass: all 2×32×32 combinations of `a`, `b` and `bin`, compared against a reference `{bout, diff} = a - b - bin`, with back-to-back handshakes.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done/ack handshake and operand/result bundle for the serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 5
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ack;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin, ack,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin, ack,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial borrow-ripple subtractor, diff = a - b - bin, LSB first
module serial_subtractor #(
   parameter int WIDTH = 5
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, diff_q;
   logic [CW-1:0]    cnt;
   logic             br, bout_q, ovf_q;
   logic             load, step, last;
   logic             a0, b0, d, br_next;

   // single full-subtractor cell fed from the operand shift registers
   assign a0      = a_sr[0];
   assign b0      = b_sr[0];
   assign d       = a0 ^ b0 ^ br;
   assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         diff_q <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (load) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
         br   <= bus.bin;
         cnt  <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         br     <= br_next;
         diff_q <= {d, diff_q[WIDTH-1:1]};
         cnt    <= cnt + CW'(1);
         // on the MSB cycle, br is the borrow into the MSB
         if (last) begin
            bout_q <= br_next;
            ovf_q  <= br ^ br_next;
         end
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;
   localparam int W = 5;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   serial_subtractor_if #(.WIDTH(W)) sif ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, unsigned and signed views
   task automatic ref_calc(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                           output logic [W-1:0] rdiff, output logic rbout, output logic rovf);
      int u, sa, sb, s;
      u     = int'(ra) - int'(rb) - int'(rbin);
      rbout = (u < 0);
      u     = u + (1 << W);
      rdiff = u[W-1:0];
      sa    = (ra >= (1 << (W - 1))) ? int'(ra) - (1 << W) : int'(ra);
      sb    = (rb >= (1 << (W - 1))) ? int'(rb) - (1 << W) : int'(rb);
      s     = sa - sb - int'(rbin);
      rovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
   endtask

   // Entered and left at a negedge; lat = edges from acceptance to done, -1 on timeout
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        output int lat);
      sif.a     = ta;
      sif.b     = tb;
      sif.bin   = tbin;
      sif.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sif.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (sif.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_ack();
      sif.ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sif.ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      sif.start = 1'b0;
      sif.ack   = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.bin   = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({sif.busy, sif.done, sif.diff, sif.bout, sif.ovf} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
                  sif.busy, sif.done, sif.diff, sif.bout, sif.ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tbin);
      int lat;
      logic [W-1:0] ed;
      logic eb, eo;
      ref_calc(ta, tb, tbin, ed, eb, eo);
      do_op(ta, tb, tbin, lat);
      n_cmp++;
      if (lat !== W || sif.diff !== ed || sif.bout !== eb || sif.ovf !== eo) begin
         n_bad++;
         $display("FAIL %s a=%0d b=%0d bin=%0d: got lat=%0d diff=%0d bout=%b ovf=%b, want lat=%0d diff=%0d bout=%b ovf=%b",
                  name, ta, tb, tbin, lat, sif.diff, sif.bout, sif.ovf, W, ed, eb, eo);
      end
      do_ack();
   endtask

   task automatic test_directed();
      int lat;
      do_op(5'd13, 5'd6, 1'b0, lat);
      n_cmp++;
      if (lat !== 5 || sif.diff !== 5'b00111 || sif.bout !== 1'b0 || sif.ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL dir_13_6: got lat=%0d diff=%b bout=%b ovf=%b, want lat=5 diff=00111 bout=0 ovf=0",
                  lat, sif.diff, sif.bout, sif.ovf);
      end
      do_ack();
      do_op(5'd6, 5'd13, 1'b0, lat);
      n_cmp++;
      if (sif.diff !== 5'b11001 || sif.bout !== 1'b1 || sif.ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL dir_6_13: got diff=%b bout=%b ovf=%b, want diff=11001 bout=1 ovf=0",
                  sif.diff, sif.bout, sif.ovf);
      end
      do_ack();
      do_op(5'd0, 5'd0, 1'b1, lat);
      n_cmp++;
      if (sif.diff !== 5'b11111 || sif.bout !== 1'b1) begin
         n_bad++;
         $display("FAIL dir_0_0_bin: got diff=%b bout=%b, want diff=11111 bout=1", sif.diff, sif.bout);
      end
      do_ack();
      do_op(5'd31, 5'd31, 1'b0, lat);
      n_cmp++;
      if (sif.diff !== 5'b00000 || sif.bout !== 1'b0) begin
         n_bad++;
         $display("FAIL dir_31_31: got diff=%b bout=%b, want diff=00000 bout=0", sif.diff, sif.bout);
      end
      do_ack();
   endtask

   task automatic test_overflow();
      int lat;
      do_op(5'b01111, 5'b10000, 1'b0, lat);
      n_cmp++;
      if (sif.diff !== 5'b11111 || sif.ovf !== 1'b1 || sif.bout !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_15_m16: got diff=%b bout=%b ovf=%b, want diff=11111 bout=1 ovf=1",
                  sif.diff, sif.bout, sif.ovf);
      end
      do_ack();
   endtask

   task automatic test_handshake();
      logic [W-1:0] ed, held;
      logic eb, eo;
      int lat;
      ref_calc(5'd20, 5'd7, 1'b0, ed, eb, eo);
      sif.a = 5'd20; sif.b = 5'd7; sif.bin = 1'b0; sif.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (sif.busy !== 1'b1 || sif.done !== 1'b0) begin
         n_bad++;
         $display("FAIL hs_accept: got busy=%b done=%b, want busy=1 done=0", sif.busy, sif.done);
      end
      sif.a = 5'd1; sif.b = 5'd2; sif.bin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sif.start = 1'b0;
      lat = -1;
      for (int i = 2; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (sif.done) begin
            lat = i;
            break;
         end
      end
      n_cmp++;
      if (lat !== W || sif.diff !== ed || sif.bout !== eb || sif.ovf !== eo) begin
         n_bad++;
         $display("FAIL hs_start_in_run: got lat=%0d diff=%0d bout=%b ovf=%b, want lat=%0d diff=%0d bout=%b ovf=%b",
                  lat, sif.diff, sif.bout, sif.ovf, W, ed, eb, eo);
      end
      held = sif.diff;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (sif.done !== 1'b1 || sif.diff !== held) begin
            n_bad++;
            $display("FAIL hs_hold: cycle %0d got done=%b diff=%0d, want done=1 diff=%0d",
                     i, sif.done, sif.diff, held);
         end
      end
      sif.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (sif.done !== 1'b1 || sif.diff !== ed || sif.bout !== eb) begin
         n_bad++;
         $display("FAIL hs_start_in_done: got done=%b diff=%0d bout=%b, want done=1 diff=%0d bout=%b",
                  sif.done, sif.diff, sif.bout, ed, eb);
      end
      sif.ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sif.ack   = 1'b0;
      sif.start = 1'b0;
      n_cmp++;
      if (sif.done !== 1'b0 || sif.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL hs_ack: got done=%b busy=%b, want done=0 busy=0", sif.done, sif.busy);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (sif.busy !== 1'b0 || sif.diff !== ed || sif.bout !== eb || sif.ovf !== eo) begin
         n_bad++;
         $display("FAIL hs_no_queue: got busy=%b diff=%0d bout=%b ovf=%b, want busy=0 diff=%0d bout=%b ovf=%b",
                  sif.busy, sif.diff, sif.bout, sif.ovf, ed, eb, eo);
      end
   endtask

   task automatic test_reset_mid_run();
      sif.a = 5'd3; sif.b = 5'd9; sif.bin = 1'b1; sif.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sif.start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sif.busy, sif.done, sif.diff, sif.bout, sif.ovf} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_run: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
                  sif.busy, sif.done, sif.diff, sif.bout, sif.ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_op("after_reset", 5'd13, 5'd6, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 2; c++) begin
         for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
               check_op("exhaustive", W'(x), W'(y), c[0]);
            end
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] ra, rb, ed;
      logic rbin, eb, eo;
      for (int k = 0; k < 150; k++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         ref_calc(ra, rb, rbin, ed, eb, eo);
         do_op(ra, rb, rbin, lat);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            @(negedge clk);
         end
         n_cmp++;
         if (lat !== W || sif.done !== 1'b1 || sif.diff !== ed || sif.bout !== eb || sif.ovf !== eo) begin
            n_bad++;
            $display("FAIL random a=%0d b=%0d bin=%0d: got lat=%0d done=%b diff=%0d bout=%b ovf=%b, want lat=%0d done=1 diff=%0d bout=%b ovf=%b",
                     ra, rb, rbin, lat, sif.done, sif.diff, sif.bout, sif.ovf, W, ed, eb, eo);
         end
         do_ack();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_overflow();
      test_handshake();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
